// File: rtl/lsu_mem_stage.sv
// MEM stage of the RV32I pipeline: drives loads/stores over a req/gnt/rvalid data bus,
// stalls upstream while an access is outstanding and owns the MEM/WB register.
module lsu_mem_stage #(
    parameter int unsigned RESP_TIMEOUT = 32'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_mem_valid,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_store_data,
    input  logic [4:0]  ex_mem_rd,
    input  logic        ex_mem_reg_write,
    input  logic        ex_mem_mem_read,
    input  logic        ex_mem_mem_write,
    input  logic [2:0]  ex_mem_funct3,
    output logic        mem_stall,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_wstrb,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_err,
    output logic        mem_wb_valid,
    output logic        mem_wb_reg_write,
    output logic [4:0]  mem_wb_rd,
    output logic [31:0] mem_wb_wdata,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic [31:0] r_tmo_cnt;
    logic        r_wb_valid, r_wb_rw;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_exc_valid;
    logic [1:0]  r_exc_cause;
    logic [31:0] r_exc_addr;

    logic        w_mem_op, w_f3_legal, w_misalign, w_fault, w_start, w_latch, w_timeout;
    logic [1:0]  w_fault_cause;
    logic [31:0] w_fmt_wdata, w_shifted, w_load_data;
    logic [3:0]  w_fmt_wstrb;
    logic        w_wb_valid_nxt, w_wb_rw_nxt, w_exc_valid_nxt;
    logic [4:0]  w_wb_rd_nxt;
    logic [31:0] w_wb_data_nxt, w_exc_addr_nxt;
    logic [1:0]  w_exc_cause_nxt;

    assign dbus_req         = (r_state == ST_REQ);
    assign dbus_we          = r_we;
    assign dbus_addr        = {r_addr[31:2], 2'b00};
    assign dbus_wdata       = r_wdata;
    assign dbus_wstrb       = r_wstrb;
    assign mem_wb_valid     = r_wb_valid;
    assign mem_wb_reg_write = r_wb_rw;
    assign mem_wb_rd        = r_wb_rd;
    assign mem_wb_wdata     = r_wb_data;
    assign exc_valid        = r_exc_valid;
    assign exc_cause        = r_exc_cause;
    assign exc_addr         = r_exc_addr;

    // Decode legality and alignment of the incoming access; read wins over write.
    always_comb begin
        w_mem_op   = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);
        w_f3_legal = 1'b0;
        w_misalign = 1'b0;
        case (ex_mem_funct3)
            3'b000: w_f3_legal = 1'b1;
            3'b001: begin w_f3_legal = 1'b1;            w_misalign = ex_mem_alu_result[0];       end
            3'b010: begin w_f3_legal = 1'b1;            w_misalign = |ex_mem_alu_result[1:0];    end
            3'b100: begin w_f3_legal = ex_mem_mem_read; w_misalign = 1'b0;                       end
            3'b101: begin w_f3_legal = ex_mem_mem_read; w_misalign = ex_mem_alu_result[0];       end
            default: begin w_f3_legal = 1'b0;           w_misalign = 1'b0;                       end
        endcase
        w_fault = w_mem_op & (~w_f3_legal | w_misalign);
        w_start = w_mem_op & w_f3_legal & ~w_misalign;
        if (!w_f3_legal) begin
            w_fault_cause = 2'b10;
        end else begin
            w_fault_cause = 2'b01;
        end
    end

    // Replicate store data across lanes and build byte enables from the offset.
    always_comb begin
        w_fmt_wdata = 32'd0;
        w_fmt_wstrb = 4'b0000;
        if (!ex_mem_mem_read) begin
            case (ex_mem_funct3[1:0])
                2'b00: begin w_fmt_wdata = {4{ex_mem_store_data[7:0]}};  w_fmt_wstrb = 4'b0001 << ex_mem_alu_result[1:0]; end
                2'b01: begin w_fmt_wdata = {2{ex_mem_store_data[15:0]}}; w_fmt_wstrb = 4'b0011 << ex_mem_alu_result[1:0]; end
                2'b10: begin w_fmt_wdata = ex_mem_store_data;            w_fmt_wstrb = 4'b1111;                           end
                default: begin w_fmt_wdata = 32'd0;                      w_fmt_wstrb = 4'b0000;                           end
            endcase
        end else begin
            w_fmt_wdata = 32'd0;
            w_fmt_wstrb = 4'b0000;
        end
    end

    // Extract and extend the loaded byte/halfword using the latched offset.
    always_comb begin
        w_shifted = dbus_rdata >> {r_addr[1:0], 3'b000};
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load_data = dbus_rdata;
            3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
            3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
            default: w_load_data = 32'd0;
        endcase
    end

    // Next state, stall, and next MEM/WB / exception contents.
    always_comb begin
        w_state_nxt     = r_state;
        mem_stall       = 1'b0;
        w_timeout       = 1'b0;
        w_latch         = 1'b0;
        w_wb_valid_nxt  = 1'b0;
        w_wb_rw_nxt     = 1'b0;
        w_wb_rd_nxt     = 5'd0;
        w_wb_data_nxt   = 32'd0;
        w_exc_valid_nxt = 1'b0;
        w_exc_cause_nxt = r_exc_cause;
        w_exc_addr_nxt  = r_exc_addr;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    mem_stall   = 1'b1;
                    w_latch     = 1'b1;
                    w_state_nxt = ST_REQ;
                end else if (w_fault) begin
                    w_wb_valid_nxt  = 1'b1;
                    w_exc_valid_nxt = 1'b1;
                    w_exc_cause_nxt = w_fault_cause;
                    w_exc_addr_nxt  = ex_mem_alu_result;
                end else if (ex_mem_valid) begin
                    w_wb_valid_nxt = 1'b1;
                    w_wb_rw_nxt    = ex_mem_reg_write;
                    w_wb_rd_nxt    = ex_mem_rd;
                    w_wb_data_nxt  = ex_mem_alu_result;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                mem_stall = 1'b1;
                if (dbus_gnt) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_WAIT: begin
                w_timeout = (RESP_TIMEOUT != 32'd0) && (r_tmo_cnt == RESP_TIMEOUT - 32'd1) && !dbus_rvalid;
                mem_stall = ~(dbus_rvalid | w_timeout);
                if (dbus_rvalid && !dbus_err) begin
                    w_state_nxt    = ST_IDLE;
                    w_wb_valid_nxt = 1'b1;
                    w_wb_rw_nxt    = r_reg_write & ~r_we;
                    w_wb_rd_nxt    = r_rd;
                    w_wb_data_nxt  = r_we ? 32'd0 : w_load_data;
                end else if (dbus_rvalid || w_timeout) begin
                    w_state_nxt     = ST_IDLE;
                    w_wb_valid_nxt  = 1'b1;
                    w_exc_valid_nxt = 1'b1;
                    w_exc_cause_nxt = 2'b11;
                    w_exc_addr_nxt  = r_addr;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, response timer and latched request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_tmo_cnt   <= 32'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'b0000;
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tmo_cnt <= (r_state == ST_WAIT) ? r_tmo_cnt + 32'd1 : 32'd0;
            if (w_latch) begin
                r_addr      <= ex_mem_alu_result;
                r_wdata     <= w_fmt_wdata;
                r_wstrb     <= w_fmt_wstrb;
                r_we        <= ~ex_mem_mem_read;
                r_funct3    <= ex_mem_funct3;
                r_rd        <= ex_mem_rd;
                r_reg_write <= ex_mem_reg_write;
            end
        end
    end

    // MEM/WB register and exception reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid  <= 1'b0;
            r_wb_rw     <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= 32'd0;
            r_exc_valid <= 1'b0;
            r_exc_cause <= 2'b00;
            r_exc_addr  <= 32'd0;
        end else begin
            r_wb_valid  <= w_wb_valid_nxt;
            r_wb_rw     <= w_wb_rw_nxt;
            r_wb_rd     <= w_wb_rd_nxt;
            r_wb_data   <= w_wb_data_nxt;
            r_exc_valid <= w_exc_valid_nxt;
            r_exc_cause <= w_exc_cause_nxt;
            r_exc_addr  <= w_exc_addr_nxt;
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Testbench for lsu_mem_stage: directed scenarios plus randomized loads/stores checked
// against a byte-array memory model.
module tb_lsu_mem_stage;
    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write;
    logic [31:0] ex_mem_alu_result, ex_mem_store_data;
    logic [4:0]  ex_mem_rd;
    logic [2:0]  ex_mem_funct3;
    logic        mem_stall, dbus_req, dbus_we, dbus_gnt, dbus_rvalid, dbus_err;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_wstrb;
    logic        mem_wb_valid, mem_wb_reg_write, exc_valid;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_wdata, exc_addr;
    logic [1:0]  exc_cause;

    always #5 clk = ~clk;

    lsu_mem_stage #(.RESP_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_mem_valid(ex_mem_valid), .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_store_data(ex_mem_store_data), .ex_mem_rd(ex_mem_rd),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read),
        .ex_mem_mem_write(ex_mem_mem_write), .ex_mem_funct3(ex_mem_funct3),
        .mem_stall(mem_stall), .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
        .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
        .dbus_err(dbus_err), .mem_wb_valid(mem_wb_valid),
        .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd),
        .mem_wb_wdata(mem_wb_wdata), .exc_valid(exc_valid), .exc_cause(exc_cause),
        .exc_addr(exc_addr)
    );

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0] bus_mem [0:1023];
    logic [7:0] ref_mem [0:1023];

    int          o_stall, o_req_cycles;
    logic        o_stable, o_wb_valid, o_wb_rw, o_exc_v;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data, o_exc_a, o_addr, o_wdata;
    logic [1:0]  o_exc_c;
    logic [3:0]  o_wstrb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_idle();
        ex_mem_valid = 1'b0; ex_mem_reg_write = 1'b0; ex_mem_mem_read = 1'b0;
        ex_mem_mem_write = 1'b0; ex_mem_alu_result = 32'd0; ex_mem_store_data = 32'd0;
        ex_mem_rd = 5'd0; ex_mem_funct3 = 3'd0;
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_err = 1'b0; dbus_rdata = 32'd0;
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        else if (f3[1:0] == 2'b01) return 2;
        else return 4;
    endfunction

    function automatic logic is_legal(input logic ld, input logic [2:0] f3);
        if (ld) return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        else return (f3 <= 3'd2);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
        logic [31:0] v;
        int n;
        n = size_of(f3);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
        if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input int a, input logic [31:0] d);
        for (int i = 0; i < size_of(f3); i++) ref_mem[a + i] = d[8 * i +: 8];
    endtask

    // One instruction through MEM, with the bench acting as bus slave.
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                          input logic rw, input int gd, input int rdl, input logic err);
        int cyc, gcnt, rcnt, base;
        logic granted, done;
        ex_mem_valid = 1'b1; ex_mem_mem_read = ld; ex_mem_mem_write = st;
        ex_mem_funct3 = f3; ex_mem_alu_result = addr; ex_mem_store_data = sd;
        ex_mem_rd = rd; ex_mem_reg_write = rw;
        cyc = 0; gcnt = 0; rcnt = 0; granted = 1'b0; done = 1'b0;
        o_stall = 0; o_req_cycles = 0; o_stable = 1'b1;
        while (!done && cyc < 60) begin
            dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_err = 1'b0; dbus_rdata = 32'hDEAD_BEEF;
            if (granted) begin
                if (rcnt == rdl) begin
                    base = int'(o_addr[9:0]);
                    dbus_rvalid = 1'b1;
                    dbus_err = err;
                    dbus_rdata = {bus_mem[base + 3], bus_mem[base + 2], bus_mem[base + 1], bus_mem[base]};
                end
                rcnt++;
            end else if (dbus_req) begin
                if (o_req_cycles == 0) begin
                    o_addr = dbus_addr; o_wdata = dbus_wdata; o_wstrb = dbus_wstrb;
                end else if (o_addr !== dbus_addr || o_wdata !== dbus_wdata || o_wstrb !== dbus_wstrb) begin
                    o_stable = 1'b0;
                end
                o_req_cycles++;
                if (gcnt == gd) begin
                    dbus_gnt = 1'b1;
                    granted = 1'b1;
                    base = int'(dbus_addr[9:0]);
                    if (dbus_we)
                        for (int i = 0; i < 4; i++)
                            if (dbus_wstrb[i]) bus_mem[base + i] = dbus_wdata[8 * i +: 8];
                end
                gcnt++;
            end
            #1;
            if (mem_stall) o_stall++;
            else done = 1'b1;
            tick();
            cyc++;
        end
        chk("op_bound", 32'(done), 32'd1);
        drive_idle();
        o_wb_valid = mem_wb_valid; o_wb_rw = mem_wb_reg_write; o_wb_rd = mem_wb_rd;
        o_wb_data = mem_wb_wdata; o_exc_v = exc_valid; o_exc_c = exc_cause; o_exc_a = exc_addr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b;
        logic [2:0]  f3;
        logic [2:0]  ldf3 [0:4];
        logic [31:0] addr, sd, exp_data;
        logic [4:0]  rd;
        logic        ld, st, rw, mem, lg, mis, flt, er;
        int          kind, sz, gd, rdl;

        ldf3[0] = 3'd0; ldf3[1] = 3'd1; ldf3[2] = 3'd2; ldf3[3] = 3'd4; ldf3[4] = 3'd5;
        for (int i = 0; i < 1024; i++) begin
            b = 8'($urandom);
            bus_mem[i] = b;
            ref_mem[i] = b;
        end
        rst_n = 1'b0;
        drive_idle();
        tick(); tick(); tick();
        chk("rst_wb_valid", 32'(mem_wb_valid), 32'd0);
        chk("rst_dbus_req", 32'(dbus_req), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_exc_valid", 32'(exc_valid), 32'd0);
        chk("rst_exc_addr", exc_addr, 32'd0);
        chk("rst_wstrb", 32'(dbus_wstrb), 32'd0);
        rst_n = 1'b1;
        tick();

        // ALU pass-through
        run_op(1'b0, 1'b0, 3'd0, 32'h37, 32'd0, 5'd10, 1'b1, 0, 0, 1'b0);
        chk("alu_stall", 32'(o_stall), 32'd0);
        chk("alu_wdata", o_wb_data, 32'h37);
        chk("alu_rd", 32'(o_wb_rd), 32'd10);
        chk("alu_rw", 32'(o_wb_rw), 32'd1);

        // LB / LBU at 0x103 of word 0x80FF_1234
        bus_mem[256] = 8'h34; bus_mem[257] = 8'h12; bus_mem[258] = 8'hFF; bus_mem[259] = 8'h80;
        ref_mem[256] = 8'h34; ref_mem[257] = 8'h12; ref_mem[258] = 8'hFF; ref_mem[259] = 8'h80;
        run_op(1'b1, 1'b0, 3'd0, 32'h103, 32'd0, 5'd5, 1'b1, 0, 0, 1'b0);
        chk("lb_stall", 32'(o_stall), 32'd2);
        chk("lb_addr", o_addr, 32'h100);
        chk("lb_wdata", o_wb_data, 32'hFFFF_FF80);
        run_op(1'b1, 1'b0, 3'd4, 32'h103, 32'd0, 5'd5, 1'b1, 0, 0, 1'b0);
        chk("lbu_wdata", o_wb_data, 32'h0000_0080);

        // SH at 0x202 with delayed grant
        run_op(1'b0, 1'b1, 3'd1, 32'h202, 32'h0000_ABCD, 5'd3, 1'b1, 3, 0, 1'b0);
        ref_store(3'd1, 32'h202, 32'h0000_ABCD);
        chk("sh_addr", o_addr, 32'h200);
        chk("sh_wstrb", 32'(o_wstrb), 32'hC);
        chk("sh_wdata", o_wdata, 32'hABCD_ABCD);
        chk("sh_stable", 32'(o_stable), 32'd1);
        chk("sh_req_cycles", 32'(o_req_cycles), 32'd4);
        chk("sh_stall", 32'(o_stall), 32'd5);
        chk("sh_rw", 32'(o_wb_rw), 32'd0);

        // Misaligned LW
        run_op(1'b1, 1'b0, 3'd2, 32'h006, 32'd0, 5'd7, 1'b1, 0, 0, 1'b0);
        chk("mis_req", 32'(o_req_cycles), 32'd0);
        chk("mis_stall", 32'(o_stall), 32'd0);
        chk("mis_exc_v", 32'(o_exc_v), 32'd1);
        chk("mis_cause", 32'(o_exc_c), 32'd1);
        chk("mis_exc_addr", o_exc_a, 32'h006);
        chk("mis_rw", 32'(o_wb_rw), 32'd0);
        tick();
        chk("exc_pulse_end", 32'(exc_valid), 32'd0);
        chk("exc_addr_hold", exc_addr, 32'h006);

        // Timeout and bus error
        run_op(1'b1, 1'b0, 3'd2, 32'h40, 32'd0, 5'd8, 1'b1, 0, 1000, 1'b0);
        chk("tmo_stall", 32'(o_stall), 32'd5);
        chk("tmo_cause", 32'(o_exc_c), 32'd3);
        chk("tmo_exc_v", 32'(o_exc_v), 32'd1);
        chk("tmo_exc_addr", o_exc_a, 32'h40);
        chk("tmo_rw", 32'(o_wb_rw), 32'd0);
        run_op(1'b1, 1'b0, 3'd2, 32'h44, 32'd0, 5'd8, 1'b1, 0, 1, 1'b1);
        chk("err_stall", 32'(o_stall), 32'd3);
        chk("err_cause", 32'(o_exc_c), 32'd3);
        chk("err_exc_addr", o_exc_a, 32'h44);

        // Spurious response in IDLE
        dbus_rvalid = 1'b1; dbus_rdata = 32'h1234_5678;
        #1;
        chk("spur_stall", 32'(mem_stall), 32'd0);
        tick();
        dbus_rvalid = 1'b0;
        chk("spur_wb_valid", 32'(mem_wb_valid), 32'd0);

        // Reset while waiting for a response
        ex_mem_valid = 1'b1; ex_mem_mem_read = 1'b1; ex_mem_funct3 = 3'd2;
        ex_mem_alu_result = 32'h40; ex_mem_rd = 5'd9; ex_mem_reg_write = 1'b1;
        tick();
        dbus_gnt = 1'b1;
        #1;
        chk("rstw_req", 32'(dbus_req), 32'd1);
        tick();
        dbus_gnt = 1'b0;
        #1;
        chk("rstw_stall_before", 32'(mem_stall), 32'd1);
        rst_n = 1'b0;
        drive_idle();
        #1;
        chk("rstw_req_low", 32'(dbus_req), 32'd0);
        chk("rstw_stall_low", 32'(mem_stall), 32'd0);
        chk("rstw_wb_valid", 32'(mem_wb_valid), 32'd0);
        chk("rstw_wb_rw", 32'(mem_wb_reg_write), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        exp_data = ref_load(3'd2, 32'h40);
        run_op(1'b1, 1'b0, 3'd2, 32'h40, 32'd0, 5'd9, 1'b1, 1, 1, 1'b0);
        chk("post_rst_stall", 32'(o_stall), 32'd4);
        chk("post_rst_data", o_wb_data, exp_data);
        chk("post_rst_rd", 32'(o_wb_rd), 32'd9);

        // Randomized mix against the memory model
        for (int k = 0; k < 60; k++) begin
            kind = $urandom_range(0, 3);
            ld = (kind == 1 || kind == 2);
            st = (kind == 3);
            if (ld) f3 = ldf3[$urandom_range(0, 4)];
            else f3 = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            sz = size_of(f3);
            addr = 32'h100 + 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(sz - 1);
            if (kind == 0) addr = $urandom;
            sd = $urandom;
            rd = 5'($urandom_range(1, 31));
            rw = ld ? 1'b1 : 1'($urandom_range(0, 1));
            mem = ld | st;
            lg = is_legal(ld, f3);
            mis = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
            flt = mem && (!lg || mis);
            er = ld && !flt && ($urandom_range(0, 7) == 0);
            gd = $urandom_range(0, 3);
            rdl = $urandom_range(0, 2);
            exp_data = (ld && !flt) ? ref_load(f3, int'(addr[9:0])) : addr;
            run_op(ld, st, f3, addr, sd, rd, rw, gd, rdl, er);
            chk("rnd_stall", 32'(o_stall), (mem && !flt) ? 32'(2 + gd + rdl) : 32'd0);
            chk("rnd_req_cycles", 32'(o_req_cycles), (mem && !flt) ? 32'(gd + 1) : 32'd0);
            chk("rnd_exc_v", 32'(o_exc_v), 32'(flt || er));
            chk("rnd_rw", 32'(o_wb_rw), (kind == 0) ? 32'(rw) : 32'(ld && !flt && !er));
            if (flt) begin
                chk("rnd_flt_cause", 32'(o_exc_c), !lg ? 32'd2 : 32'd1);
                chk("rnd_flt_addr", o_exc_a, addr);
            end else if (er) begin
                chk("rnd_err_cause", 32'(o_exc_c), 32'd3);
                chk("rnd_err_addr", o_exc_a, addr);
            end else begin
                chk("rnd_wb_valid", 32'(o_wb_valid), 32'd1);
                chk("rnd_wb_rd", 32'(o_wb_rd), 32'(rd));
                if (!st) chk("rnd_wb_data", o_wb_data, exp_data);
                if (ld) chk("rnd_ld_wstrb", 32'(o_wstrb), 32'd0);
            end
            if (st && !flt) ref_store(f3, int'(addr[9:0]), sd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
